// File: rtl/adc_xy_fb_sched.sv
// ADC X/Y capture sequencer sharing the framebuffer write port
// between live ADC pixels and a full-screen clear sweep.
module adc_xy_fb_sched #(
  parameter int DATA_BITS      = 10,
  parameter int FB_WIDTH       = 640,
  parameter int FB_HEIGHT      = 480,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int DRAIN_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_req,
  output logic                      adc_enable,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_BITS-1:0]      s_x,
  input  logic [DATA_BITS-1:0]      s_y,
  input  logic                      s_red,
  input  logic                      s_grn,
  input  logic                      s_blu,
  output logic                      fb_wr_valid,
  input  logic                      fb_wr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [2:0]                fb_wr_color,
  output logic                      busy,
  output logic                      clear_done,
  output logic [15:0]               drop_cnt
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] W_A    = AW'(FB_WIDTH);
  localparam logic [AW-1:0] H_A    = AW'(FB_HEIGHT);
  localparam logic [AW-1:0] NPIX_A = AW'(FB_WIDTH * FB_HEIGHT);
  localparam logic [CW-1:0] IDLE_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          adc_en_q, adc_en_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [15:0]   drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    color_q, color_d;

  logic          load_ok;
  logic          adc_hs;
  logic          on_screen;
  logic          clr_load;
  logic          clr_fin;
  logic          idle_hit;
  logic [AW-1:0] x_w;
  logic [AW-1:0] y_w;

  assign x_w       = AW'(s_x);
  assign y_w       = AW'(s_y);
  assign load_ok   = !valid_q || fb_wr_ready;
  assign s_tready  = (state_q == S_RUN || state_q == S_DRAIN) && load_ok;
  assign adc_hs    = s_tvalid && s_tready;
  assign on_screen = (x_w < W_A) && (y_w < H_A);
  assign clr_load  = (state_q == S_CLEAR) && load_ok
                  && (clr_addr_q < NPIX_A);
  // clr_addr sits at NPIX only once the last clear word is held
  assign clr_fin   = (state_q == S_CLEAR) && valid_q && fb_wr_ready
                  && (clr_addr_q == NPIX_A);
  assign idle_hit  = (state_q == S_DRAIN) && !s_tvalid && !valid_q
                  && (idle_q == IDLE_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_CLEAR;
        else if (enable) state_d = S_RUN;
      end
      S_CLEAR: begin
        if (clr_fin) state_d = S_IDLE;
      end
      S_RUN: begin
        if (!enable || pend_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (idle_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adc_en_d   = (state_d == S_RUN);
    pend_d     = pend_q;
    clr_addr_d = clr_addr_q;
    idle_d     = '0;
    drop_d     = drop_q;
    valid_d    = valid_q && !fb_wr_ready;
    addr_d     = addr_q;
    color_d    = color_q;

    if (state_q != S_CLEAR && clear_req) pend_d = 1'b1;
    if (state_q != S_CLEAR && state_d == S_CLEAR) pend_d = 1'b0;

    if (state_q == S_DRAIN) begin
      if (s_tvalid) idle_d = '0;
      else if (!valid_q) idle_d = idle_q + 1'b1;
      else idle_d = idle_q;
    end

    if (adc_hs) begin
      if (on_screen) begin
        valid_d = 1'b1;
        addr_d  = y_w * W_A + x_w;
        color_d = {s_red, s_grn, s_blu};
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end

    if (clr_load) begin
      valid_d    = 1'b1;
      addr_d     = clr_addr_q;
      color_d    = 3'b000;
      clr_addr_d = clr_addr_q + 1'b1;
    end
    if (clr_fin) clr_addr_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      adc_en_q   <= 1'b0;
      clr_addr_q <= '0;
      idle_q     <= '0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      adc_en_q   <= adc_en_d;
      clr_addr_q <= clr_addr_d;
      idle_q     <= idle_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      color_q    <= color_d;
    end
  end

  assign adc_enable  = adc_en_q;
  assign fb_wr_valid = valid_q;
  assign fb_wr_addr  = addr_q;
  assign fb_wr_color = color_q;
  assign busy        = (state_q != S_IDLE);
  assign clear_done  = clr_fin;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_adc_xy_fb_sched.sv
// Directed bench for adc_xy_fb_sched; a short framebuffer
// (640x4) keeps full clear sweeps cheap.
module tb_adc_xy_fb_sched;

  localparam int W    = 640;
  localparam int H    = 4;
  localparam int AW   = 20;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear_req;
  logic          adc_enable;
  logic          s_tvalid;
  logic          s_tready;
  logic [9:0]    s_x;
  logic [9:0]    s_y;
  logic          s_red;
  logic          s_grn;
  logic          s_blu;
  logic          fb_wr_valid;
  logic          fb_wr_ready;
  logic [AW-1:0] fb_wr_addr;
  logic [2:0]    fb_wr_color;
  logic          busy;
  logic          clear_done;
  logic [15:0]   drop_cnt;

  adc_xy_fb_sched #(
    .DATA_BITS(10), .FB_WIDTH(W), .FB_HEIGHT(H),
    .AXI_ADDR_WIDTH(AW), .DRAIN_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_req(clear_req), .adc_enable(adc_enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_x(s_x), .s_y(s_y),
    .s_red(s_red), .s_grn(s_grn), .s_blu(s_blu),
    .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
    .fb_wr_addr(fb_wr_addr), .fb_wr_color(fb_wr_color),
    .busy(busy), .clear_done(clear_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int done_cnt = 0;
  int hold_viol = 0;
  logic [22:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // ready pattern: 0 high, 1 random, 2 toggle, 3 low
  initial begin
    fb_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: fb_wr_ready = 1'($urandom_range(0, 1));
        2: fb_wr_ready = ~fb_wr_ready;
        3: fb_wr_ready = 1'b0;
        default: fb_wr_ready = 1'b1;
      endcase
    end
  end

  logic          prev_stall = 1'b0;
  logic [AW-1:0] p_addr;
  logic [2:0]    p_col;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!fb_wr_valid || fb_wr_addr != p_addr
                         || fb_wr_color != p_col))
        hold_viol++;
      if (fb_wr_valid && fb_wr_ready)
        wq.push_back({fb_wr_addr, fb_wr_color});
      if (clear_done) done_cnt++;
      prev_stall = fb_wr_valid && !fb_wr_ready;
      p_addr = fb_wr_addr;
      p_col = fb_wr_color;
    end
  end

  task automatic send(input int x, input int y, input int c);
    bit ok;
    ok = 1'b0;
    s_tvalid = 1'b1;
    s_x = 10'(x);
    s_y = 10'(y);
    {s_red, s_grn, s_blu} = 3'(c);
    for (int k = 0; k < 200 && !ok; k++) begin
      if (s_tready) ok = 1'b1;
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int lim);
    int k;
    k = 0;
    while (done_cnt < target && k < lim) begin
      tick();
      k++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic wait_wq(input int n, input int lim);
    int k;
    k = 0;
    while (wq.size() < n && k < lim) begin
      tick();
      k++;
    end
    if (wq.size() < n) chk("wq_timeout", wq.size(), n);
  endtask

  task automatic chk_clear(input string tag, input int base);
    int bad;
    logic [22:0] e;
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      e = {AW'(i), 3'b000};
      if (base + i >= wq.size() || wq[base + i] != e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int bad;
    int c0;
    int k;
    logic [22:0] e;
    reset = 1'b1;
    enable = 1'b0;
    clear_req = 1'b0;
    s_tvalid = 1'b0;
    s_x = '0;
    s_y = '0;
    {s_red, s_grn, s_blu} = 3'b000;
    repeat (3) tick();
    chk("rst_adc_en", adc_enable, 0);
    chk("rst_valid", fb_wr_valid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_done", clear_done, 0);
    reset = 1'b0;
    tick();

    enable = 1'b1;
    tick();
    chk("run_adc_en", adc_enable, 1);
    send(3, 2, 3'b100);
    s_tvalid = 1'b0;
    chk("px_valid", fb_wr_valid, 1);
    chk("px_addr", fb_wr_addr, 1283);
    chk("px_color", fb_wr_color, 3'b100);
    tick();
    chk("px_count", wq.size(), 1);
    wq.delete();

    c0 = cyc;
    for (int i = 0; i < 100; i++) send((i * 7) % W, i % H, i % 8);
    s_tvalid = 1'b0;
    chk("b2b_cycles", cyc - c0, 100);
    repeat (2) tick();
    chk("b2b_count", wq.size(), 100);
    bad = 0;
    for (int i = 0; i < 100 && i < wq.size(); i++) begin
      e = {AW'((i % H) * W + (i * 7) % W), 3'(i % 8)};
      if (wq[i] != e) bad++;
    end
    chk("b2b_order", bad, 0);
    wq.delete();

    rdy_mode = 2;
    for (int i = 0; i < 20; i++)
      send((i * 13 + 100) % W, (i + 1) % H, 7 - (i % 8));
    s_tvalid = 1'b0;
    rdy_mode = 0;
    repeat (4) tick();
    chk("stall_count", wq.size(), 20);
    bad = 0;
    for (int i = 0; i < 20 && i < wq.size(); i++) begin
      e = {AW'(((i + 1) % H) * W + (i * 13 + 100) % W), 3'(7 - (i % 8))};
      if (wq[i] != e) bad++;
    end
    chk("stall_order", bad, 0);
    chk("stall_hold", hold_viol, 0);
    wq.delete();

    send(640, 0, 1);
    send(0, H, 2);
    send(639, H - 1, 5);
    s_tvalid = 1'b0;
    repeat (2) tick();
    chk("edge_count", wq.size(), 1);
    e = {AW'(2559), 3'd5};
    chk("edge_addr", (wq.size() > 0) ? wq[0] : 23'd0, e);
    chk("drop_two", drop_cnt, 2);
    wq.delete();
    for (int i = 0; i < 65540; i++) send(700, 5, 0);
    s_tvalid = 1'b0;
    tick();
    chk("drop_sat", drop_cnt, 16'hFFFF);
    chk("drop_nowr", wq.size(), 0);

    rdy_mode = 3;
    tick();
    send(10, 1, 1);
    s_tvalid = 1'b1;
    s_x = 10'd20;
    {s_red, s_grn, s_blu} = 3'd2;
    tick();
    pulse_clear();
    tick();
    chk("drain_adc_off", adc_enable, 0);
    chk("drain_held", fb_wr_valid, 1);
    chk("drain_nowr", wq.size(), 0);
    rdy_mode = 0;
    for (int i = 1; i < 5; i++) send(10 * (i + 1), 1, i + 1);
    s_tvalid = 1'b0;
    k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    chk("drain_len", k, 17);
    wait_done(1, 4000);
    repeat (3) tick();
    chk("clr1_count", wq.size(), 5 + NPIX);
    bad = 0;
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      e = {AW'(W + 10 * (i + 1)), 3'(i + 1)};
      if (wq[i] != e) bad++;
    end
    chk("flight_order", bad, 0);
    chk_clear("clr1_seq", 5);
    chk("clr1_done", done_cnt, 1);
    chk("clr1_rerun", adc_enable, 1);
    wq.delete();

    rdy_mode = 1;
    pulse_clear();
    wait_wq(10, 200);
    pulse_clear();
    wait_done(2, 20000);
    rdy_mode = 0;
    repeat (50) tick();
    chk("clr2_count", wq.size(), NPIX);
    chk_clear("clr2_seq", 0);
    chk("clr2_done", done_cnt, 2);
    chk("clr2_rerun", adc_enable, 1);
    chk("clr2_hold", hold_viol, 0);
    wq.delete();

    pulse_clear();
    wait_wq(1000, 3000);
    reset = 1'b1;
    #1;
    chk("mid_valid", fb_wr_valid, 0);
    chk("mid_addr", fb_wr_addr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_adc_en", adc_enable, 0);
    chk("mid_drop", drop_cnt, 0);
    chk("mid_tready", s_tready, 0);
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_busy", busy, 0);
    chk("post_valid", fb_wr_valid, 0);
    wq.delete();
    pulse_clear();
    wait_done(3, 4000);
    repeat (2) tick();
    chk("clr3_count", wq.size(), NPIX);
    chk_clear("clr3_seq", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
